// File: rtl/qam_defs.sv
// Shared QAM demodulator definitions: tracking states, the sample-rate base
// and the baud/modulation decode common to the transmit clock generator.
package qam_defs;

  localparam int SPS_BASE = 96;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } trk_state_t;

  // Samples per symbol: 96/48/24/12 for 2400..19200 Baud.
  function automatic logic [6:0] sps_of(input logic [1:0] baud_rate);
    return 7'(SPS_BASE >> baud_rate);
  endfunction

  // Samples between bit strobes: N/2 for QPSK, N/4 for 16QAM.
  function automatic logic [6:0] bit_spacing(input logic mod_type, input logic [1:0] baud_rate);
    return mod_type ? (sps_of(baud_rate) >> 2) : (sps_of(baud_rate) >> 1);
  endfunction

endpackage

// File: rtl/sym_phase_cnt.sv
// Samples-per-symbol phase counter with edge-driven correction and
// registered symbol-centre / bit strobes on target entry.
module sym_phase_cnt
  import qam_defs::*;
(
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              sample_en,
  input  logic              edge_hit,
  input  logic              align,
  input  logic [6:0]        sps,
  input  logic [6:0]        spacing,
  output logic signed [7:0] err,
  output logic              sym_en,
  output logic              bit_en,
  output logic [1:0]        bit_idx
);

  logic [6:0] cnt_p0, cnt_nxt, half, step1, step2;
  logic       ent1, ent2;
  logic [2:0] tgt1, tgt2;

  // {hit, k} for bit targets at (N/2 + k*S) mod N.
  function automatic logic [2:0] bit_target(input logic [6:0] v, input logic [6:0] h,
                                            input logic [6:0] s);
    logic [7:0] d, s8;
    d  = {1'b0, (v >= h) ? v - h : v + h};
    s8 = {1'b0, s};
    if (d == 8'd0)      return 3'b100;
    if (d == s8)        return 3'b101;
    if (d == (s8 << 1)) return 3'b110;
    if (d == s8 * 8'd3) return 3'b111;
    return 3'b000;
  endfunction

  assign half  = sps >> 1;
  assign err   = (cnt_p0 < half) ? $signed({1'b0, cnt_p0})
                                 : $signed({1'b0, cnt_p0}) - $signed({1'b0, sps});
  assign step1 = (cnt_p0 == sps - 7'd1) ? 7'd0 : cnt_p0 + 7'd1;
  assign step2 = (step1 == sps - 7'd1) ? 7'd0 : step1 + 7'd1;
  assign tgt1  = bit_target(step1, half, spacing);
  assign tgt2  = bit_target(step2, half, spacing);

  // A +2 advance enters both step1 and step2 so no target is skipped.
  always_comb begin
    cnt_nxt = cnt_p0;
    ent1    = 1'b0;
    ent2    = 1'b0;
    if (sample_en) begin
      if (edge_hit && align) begin
        cnt_nxt = 7'd1;
      end else if (edge_hit && err > 8'sd0) begin
        cnt_nxt = cnt_p0;
      end else if (edge_hit && err < 8'sd0) begin
        cnt_nxt = step2;
        ent1    = 1'b1;
        ent2    = 1'b1;
      end else begin
        cnt_nxt = step1;
        ent1    = 1'b1;
      end
    end
  end

  // Stage p0: counter state and strobes
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0  <= 7'd0;
      sym_en  <= 1'b0;
      bit_en  <= 1'b0;
      bit_idx <= 2'd0;
    end else if (clr) begin
      cnt_p0  <= 7'd0;
      sym_en  <= 1'b0;
      bit_en  <= 1'b0;
      bit_idx <= 2'd0;
    end else begin
      cnt_p0  <= cnt_nxt;
      sym_en  <= (ent1 && step1 == half) || (ent2 && step2 == half);
      bit_en  <= (ent1 && tgt1[2]) || (ent2 && tgt2[2]);
      bit_idx <= (ent1 && tgt1[2]) ? tgt1[1:0] :
                 (ent2 && tgt2[2]) ? tgt2[1:0] : 2'd0;
    end
  end

endmodule

// File: rtl/sym_timing_rec.sv
// Receiver symbol timing recovery: SEARCH/TRACK/LOCKED FSM around the phase
// counter. Define SYM_TIMING_ERR_OUT_EN to expose the last edge phase error.
module sym_timing_rec
  import qam_defs::*;
#(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       mod_type,
  input  logic [1:0] baud_rate,
  input  logic       sample_en,
  input  logic       edge_det,
  output logic       sym_en,
  output logic       bit_en,
  output logic [1:0] bit_idx,
  output logic       locked
`ifdef SYM_TIMING_ERR_OUT_EN
  ,
  output logic signed [7:0] phase_err
`endif
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  trk_state_t        state;
  logic [GW-1:0]     good_cnt;
  logic [BW-1:0]     bad_cnt;
  logic              mod_q;
  logic [1:0]        baud_q;
  logic              cfg_chg, edge_hit, is_good, is_bad;
  logic [6:0]        sps, spacing;
  logic signed [7:0] err;
  logic [7:0]        err_mag;

  assign cfg_chg  = (mod_type != mod_q) || (baud_rate != baud_q);
  assign edge_hit = edge_det && sample_en;
  assign sps      = sps_of(baud_q);
  assign spacing  = bit_spacing(mod_q, baud_q);
  assign err_mag  = err[7] ? $unsigned(-err) : $unsigned(err);
  assign is_good  = err_mag <= 8'd1;
  assign is_bad   = err_mag > {1'b0, sps >> 2};

  sym_phase_cnt u_cnt (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .clr       (cfg_chg),
    .sample_en (sample_en),
    .edge_hit  (edge_hit),
    .align     (state == SEARCH),
    .sps       (sps),
    .spacing   (spacing),
    .err       (err),
    .sym_en    (sym_en),
    .bit_en    (bit_en),
    .bit_idx   (bit_idx)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mod_q  <= 1'b0;
      baud_q <= 2'd0;
    end else begin
      mod_q  <= mod_type;
      baud_q <= baud_rate;
    end
  end

  // A config change outranks a coincident edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
      bad_cnt  <= '0;
      locked   <= 1'b0;
    end else if (cfg_chg) begin
      state    <= SEARCH;
      good_cnt <= '0;
      bad_cnt  <= '0;
      locked   <= 1'b0;
    end else if (edge_hit) begin
      case (state)
        SEARCH: begin
          state    <= TRACK;
          good_cnt <= '0;
          bad_cnt  <= '0;
        end
        TRACK: begin
          if (!is_good) begin
            good_cnt <= '0;
          end else if (good_cnt == GW'(LOCK_CNT - 1)) begin
            state    <= LOCKED;
            locked   <= 1'b1;
            good_cnt <= '0;
            bad_cnt  <= '0;
          end else begin
            good_cnt <= good_cnt + GW'(1);
          end
        end
        LOCKED: begin
          if (!is_bad) begin
            bad_cnt <= '0;
          end else if (bad_cnt == BW'(UNLOCK_CNT - 1)) begin
            state   <= SEARCH;
            locked  <= 1'b0;
            bad_cnt <= '0;
          end else begin
            bad_cnt <= bad_cnt + BW'(1);
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYM_TIMING_ERR_OUT_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)        phase_err <= 8'sd0;
    else if (cfg_chg)  phase_err <= 8'sd0;
    else if (edge_hit) phase_err <= err;
  end
`endif

endmodule

// File: tb/tb_sym_timing_rec.sv
// Self-checking bench for sym_timing_rec: vector table, directed corner
// sequences and randomized edges against an arithmetic reference model.
module tb_sym_timing_rec;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       mod_type, sample_en, edge_det;
  logic [1:0] baud_rate;
  logic       sym_en, bit_en, locked;
  logic [1:0] bit_idx;
`ifdef SYM_TIMING_ERR_OUT_EN
  logic signed [7:0] phase_err;
`endif

  always #5 clk_in = ~clk_in;

  sym_timing_rec #(.LOCK_CNT(8), .UNLOCK_CNT(4)) u_dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .mod_type  (mod_type),
    .baud_rate (baud_rate),
    .sample_en (sample_en),
    .edge_det  (edge_det),
    .sym_en    (sym_en),
    .bit_en    (bit_en),
    .bit_idx   (bit_idx),
    .locked    (locked)
`ifdef SYM_TIMING_ERR_OUT_EN
    ,
    .phase_err (phase_err)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model state (state 0/1/2 = search/track/locked)
  int m_cnt, m_state, m_good, m_bad, m_mod, m_baud, m_err;
  bit e_sym, e_bit, e_lock;
  int e_idx;

  bit win_on = 1'b0;
  bit win_seen;
  int win_bits;

  typedef struct {
    bit       mod;
    bit [1:0] baud;
    bit       se;
    bit       ed;
    bit       sym;
    bit       ben;
    bit [1:0] idx;
    bit       lk;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_state = 0; m_good = 0; m_bad = 0; m_mod = 0; m_baud = 0; m_err = 0;
    e_sym = 0; e_bit = 0; e_idx = 0; e_lock = 0;
  endtask

  task automatic model(input bit mod, input bit [1:0] baud, input bit se, input bit ed);
    int n, s, half, adv, d, mag;
    e_sym = 0; e_bit = 0; e_idx = 0;
    if (int'(mod) != m_mod || int'(baud) != m_baud) begin
      m_mod = mod; m_baud = baud;
      m_cnt = 0; m_state = 0; m_good = 0; m_bad = 0; m_err = 0; e_lock = 0;
      return;
    end
    if (!se) return;
    n    = 96 >> baud;
    s    = mod ? n / 4 : n / 2;
    half = n / 2;
    adv  = 1;
    if (ed) begin
      m_err = (m_cnt < half) ? m_cnt : m_cnt - n;
      mag   = (m_err < 0) ? -m_err : m_err;
      if (m_state == 0) begin
        m_cnt = 1; adv = 0; m_state = 1; m_good = 0; m_bad = 0;
      end else begin
        adv = (m_err == 0) ? 1 : (m_err > 0) ? 0 : 2;
        if (m_state == 1) begin
          if (mag <= 1) begin
            m_good++;
            if (m_good == 8) begin m_state = 2; m_good = 0; m_bad = 0; end
          end else m_good = 0;
        end else begin
          if (mag > n / 4) begin
            m_bad++;
            if (m_bad == 4) begin m_state = 0; m_bad = 0; end
          end else m_bad = 0;
        end
      end
    end
    for (int i = 0; i < adv; i++) begin
      m_cnt = (m_cnt + 1) % n;
      d = (m_cnt - half + n) % n;
      if (m_cnt == half) e_sym = 1;
      if (d % s == 0) begin e_bit = 1; e_idx = d / s; end
    end
    e_lock = (m_state == 2);
  endtask

  // Called at posedge+1; applies one cycle of inputs and checks the result.
  task automatic drive(input bit mod, input bit [1:0] baud, input bit se, input bit ed);
    mod_type = mod; baud_rate = baud; sample_en = se; edge_det = ed;
    model(mod, baud, se, ed);
    @(posedge clk_in); #1;
    check("model_out", {sym_en, bit_en, bit_idx, locked}, {e_sym, e_bit, e_idx[1:0], e_lock});
`ifdef SYM_TIMING_ERR_OUT_EN
    check("phase_err", {24'd0, phase_err}, {24'd0, 8'(m_err)});
`endif
    if (win_on) begin
      if (sym_en) begin
        if (win_seen) check("bits_per_sym", win_bits, 4);
        win_seen = 1'b1;
        win_bits = 0;
      end
      if (bit_en) win_bits++;
    end
  endtask

  task automatic run_to(input bit mod, input bit [1:0] baud, input int tgt);
    int k;
    k = 0;
    drive(mod, baud, 1'b1, 1'b0);
    while (m_cnt != tgt && k < 200) begin
      drive(mod, baud, 1'b1, 1'b0);
      k++;
    end
    if (m_cnt != tgt) begin
      n_chk++; n_err++;
      $display("FAIL run_to_bound: cnt %0d required %0d", m_cnt, tgt);
    end
    drive(mod, baud, 1'b1, 1'b1);
  endtask

  task automatic acquire(input bit mod, input bit [1:0] baud);
    drive(mod, baud, 1'b0, 1'b0);
    drive(mod, baud, 1'b1, 1'b1);
    repeat (8) run_to(mod, baud, 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, strobes, jt, n;
    bit rm, rse, red;
    bit [1:0] rb;

    rst_n = 1'b0; mod_type = 1'b0; baud_rate = 2'd0; sample_en = 1'b0; edge_det = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_state", {sym_en, bit_en, bit_idx, locked}, 5'd0);
    @(negedge clk_in) rst_n = 1'b1;
    @(posedge clk_in); #1;

    // QPSK N=12: alignment, centre at 6, bit 0 then bit 1 six samples later
    tbl[0]  = '{0, 3, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 3, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 3, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 3, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 3, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 3, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 3, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 3, 1, 0, 1, 1, 0, 0};
    tbl[8]  = '{0, 3, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 3, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 3, 1, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 3, 1, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 3, 1, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 3, 1, 0, 0, 0, 0, 0};
    tbl[14] = '{0, 3, 1, 0, 0, 1, 1, 0};
    tbl[15] = '{0, 3, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].mod, tbl[i].baud, tbl[i].se, tbl[i].ed);
      check($sformatf("tbl%0d", i), {sym_en, bit_en, bit_idx, locked},
            {tbl[i].sym, tbl[i].ben, tbl[i].idx, tbl[i].lk});
    end

    // Edges every 12 samples with random idle cycles: lock on 8th good edge
    for (int j = 0; j < 120; j++) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, 2'd3, 1'b0, 1'b0);
      drive(1'b0, 2'd3, 1'b1, (j % 12) == 11);
    end
    check("lock_qpsk", locked, 1);

    // 16QAM N=96, edges early by 3 at first: +2 per symbol until converged
    drive(1'b1, 2'd0, 1'b0, 1'b0);
    check("cfg_drop_lock", locked, 0);
    drive(1'b1, 2'd0, 1'b1, 1'b1);
    win_on = 1'b1; win_seen = 1'b0; win_bits = 0;
    k = 93;
    for (int j = 0; j < 10; j++) begin
      repeat (k - 1) drive(1'b1, 2'd0, 1'b1, 1'b0);
      drive(1'b1, 2'd0, 1'b1, 1'b1);
      k = 96;
    end
    repeat (100) drive(1'b1, 2'd0, 1'b1, 1'b0);
    win_on = 1'b0;
    check("qam_converged_lock", locked, 1);

    // N=12 16QAM: +2 from cnt 11 crosses target 0 (bit 2) exactly once
    drive(1'b1, 2'd3, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 1'b1, 1'b1);
    repeat (10) drive(1'b1, 2'd3, 1'b1, 1'b0);
    drive(1'b1, 2'd3, 1'b1, 1'b1);
    check("skip_bit2_en", bit_en, 1);
    check("skip_bit2_idx", bit_idx, 2);
    drive(1'b1, 2'd3, 1'b1, 1'b0);
    check("skip_no_refire", bit_en, 0);

    // N=48 LOCKED: 3 bad + 1 good keeps lock, 4 bad drops it
    acquire(1'b0, 2'd1);
    check("lock_n48", locked, 1);
    repeat (3) run_to(1'b0, 2'd1, 20);
    check("three_bad_keep", locked, 1);
    run_to(1'b0, 2'd1, 0);
    repeat (3) run_to(1'b0, 2'd1, 20);
    check("bad_cleared_by_good", locked, 1);
    run_to(1'b0, 2'd1, 20);
    check("unlock_4bad", locked, 0);

    // Baud 10 -> 01 while locked
    acquire(1'b0, 2'd2);
    check("lock_n24", locked, 1);
    drive(1'b0, 2'd1, 1'b0, 1'b0);
    check("cfg_unlock", locked, 0);
    acquire(1'b0, 2'd1);
    check("reacq_n48", locked, 1);

    // Config change with coincident edge: edge discarded, cnt free-runs from 0
    drive(1'b1, 2'd1, 1'b1, 1'b1);
    k = 0;
    do begin
      drive(1'b1, 2'd1, 1'b1, 1'b0);
      k++;
    end while (!sym_en && k < 60);
    check("cfg_edge_discard", k, 24);

    // Reset while sym_en is high clears outputs without waiting for a clock
    drive(1'b0, 2'd3, 1'b0, 1'b0);
    drive(1'b0, 2'd3, 1'b1, 1'b1);
    repeat (5) drive(1'b0, 2'd3, 1'b1, 1'b0);
    check("sym_pending", sym_en, 1);
    #1 rst_n = 1'b0;
    mod_type = 1'b0; baud_rate = 2'd0; sample_en = 1'b0; edge_det = 1'b0;
    #1;
    check("rst_async_clear", {sym_en, bit_en, bit_idx, locked}, 5'd0);
    model_reset();
    @(posedge clk_in);
    @(negedge clk_in) rst_n = 1'b1;
    @(posedge clk_in); #1;
    drive(1'b0, 2'd3, 1'b0, 1'b0);
    strobes = 0;
    repeat (5) begin
      drive(1'b0, 2'd3, 1'b1, 1'b0);
      if (sym_en || bit_en) strobes++;
    end
    check("no_strobe_after_rst", strobes, 0);

    // Randomized: near-periodic edges with +-1 jitter plus stray edges
    rm = 1'b0; rb = 2'd3; jt = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rm = 1'($urandom_range(0, 1));
        rb = 2'($urandom_range(0, 3));
        jt = 0;
      end
      n   = 96 >> rb;
      rse = ($urandom_range(0, 2) != 0);
      red = rse && (m_cnt == jt);
      if ($urandom_range(0, 49) == 0) red = 1'b1;
      if (red && rse) jt = (n - 1 + int'($urandom_range(0, 2))) % n;
      drive(rm, rb, rse, red);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
